// File: rtl/arduino_io_pkg.sv
// Shared constants for crypt_engine: memory geometry, opcodes, header offsets, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arduino_io_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;

   localparam logic [7:0] OP_COPY = 8'h00;
   localparam logic [7:0] OP_XOR  = 8'h01;
   localparam logic [7:0] OP_ADD  = 8'h02;
   localparam logic [7:0] OP_SUB  = 8'h03;
   localparam logic [7:0] OP_INV  = 8'h04;

   // byte offsets of the job header in the command memory
   localparam logic [2:0] HDR_LEN_HI  = 3'd0;
   localparam logic [2:0] HDR_LEN_LO  = 3'd1;
   localparam logic [2:0] HDR_OP      = 3'd2;
   localparam logic [2:0] HDR_KLEN_HI = 3'd3;
   localparam logic [2:0] HDR_KLEN_LO = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/crypt_alu.sv
// Byte operation unit: applies the job opcode to one source byte and one key byte.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever the inputs are.
module crypt_alu
   import arduino_io_pkg::*;
(
   input  logic [DATA_W-1:0] i_op,
   input  logic [DATA_W-1:0] i_src,
   input  logic [DATA_W-1:0] i_key,
   output logic [DATA_W-1:0] o_result,
   output logic              o_op_vld
);

   // decode the opcode and compute the byte result; unknown opcodes pass src through and flag invalid
   always_comb begin
      o_result = i_src;
      o_op_vld = 1'b1;
      case (i_op)
         OP_COPY: o_result = i_src;
         OP_XOR:  o_result = i_src ^ i_key;
         OP_ADD:  o_result = i_src + i_key;
         OP_SUB:  o_result = i_src - i_key;
         OP_INV:  o_result = ~i_src;
         default: begin
            o_result = i_src;
            o_op_vld = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/crypt_engine.sv
// Job engine: reads a 5-byte header, streams len src bytes through crypt_alu with a wrapping key into dst.
// Latency: start to done is len+8 cycles (7 for len=0 or bad opcode); one byte per cycle in RUN.
// Backpressure: none; memories are owned while busy, start is ignored while busy. Option: CRYPT_ENGINE_CHECKSUM_EN.
module crypt_engine
   import arduino_io_pkg::*;
(
   input  logic              sysclk,
   input  logic              arduino_reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] checksum,
   output logic [ADDR_W-1:0] mem_cmd_ad,
   output logic              mem_cmd_ce,
   input  logic [DATA_W-1:0] mem_cmd_dout,
   output logic [ADDR_W-1:0] mem_src_ad,
   output logic              mem_src_ce,
   input  logic [DATA_W-1:0] mem_src_dout,
   output logic [ADDR_W-1:0] mem_key_ad,
   output logic              mem_key_ce,
   input  logic [DATA_W-1:0] mem_key_dout,
   output logic [ADDR_W-1:0] mem_dst_ad,
   output logic              mem_dst_ce,
   output logic              mem_dst_wre,
   output logic [DATA_W-1:0] mem_dst_din
);

   state_t            r_state;
   logic [2:0]        r_hcnt;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] r_klen;
   logic [DATA_W-1:0] r_op;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [ADDR_W-1:0] r_cmd_ad;
   logic [ADDR_W-1:0] r_src_ad;
   logic [ADDR_W-1:0] r_key_ad;
   logic [ADDR_W-1:0] r_dst_ad;
   logic              r_cmd_ce;
   logic              r_src_ce;
   logic              r_dst_wre;

   logic [DATA_W-1:0] w_result;
   logic              w_op_vld;
   logic [ADDR_W-1:0] w_kmax;
   logic [2:0]        w_cap_idx;
   logic [DATA_W-1:0] w_din;
   logic              w_unused_hdr_bits;

   crypt_alu u_alu (
      .i_op     (r_op),
      .i_src    (mem_src_dout),
      .i_key    (mem_key_dout),
      .o_result (w_result),
      .o_op_vld (w_op_vld)
   );

   // klen of 0 behaves as 1, so the last key index is 0 in that case
   assign w_kmax    = (r_klen == '0) ? '0 : r_klen - 14'd1;
   // header byte arriving this cycle was addressed one cycle earlier
   assign w_cap_idx = r_hcnt - 3'd1;
   // dst data is the ALU result of the read issued last cycle; held at zero when not writing
   assign w_din     = r_dst_wre ? w_result : '0;
   // top two bits of the length bytes carry no information
   assign w_unused_hdr_bits = ^mem_cmd_dout[7:6];

   // job sequencer: header fetch, streaming read/write pipeline, done pulse
   always_ff @(posedge sysclk) begin
      if (arduino_reset) begin
         r_state   <= ST_IDLE;
         r_hcnt    <= '0;
         r_len     <= '0;
         r_klen    <= '0;
         r_op      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_cmd_ad  <= '0;
         r_src_ad  <= '0;
         r_key_ad  <= '0;
         r_dst_ad  <= '0;
         r_cmd_ce  <= 1'b0;
         r_src_ce  <= 1'b0;
         r_dst_wre <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state  <= ST_HDR;
                  r_busy   <= 1'b1;
                  r_err    <= 1'b0;
                  r_hcnt   <= '0;
                  r_cmd_ad <= '0;
                  r_cmd_ce <= 1'b1;
                  r_src_ad <= '0;
                  r_key_ad <= '0;
                  r_dst_ad <= '0;
               end
            end
            ST_HDR: begin
               r_hcnt <= r_hcnt + 3'd1;
               if (r_hcnt < HDR_KLEN_LO) begin
                  r_cmd_ad <= r_cmd_ad + 14'd1;
               end else begin
                  r_cmd_ad <= '0;
                  r_cmd_ce <= 1'b0;
               end
               case (w_cap_idx)
                  HDR_LEN_HI:  r_len[13:8]  <= mem_cmd_dout[5:0];
                  HDR_LEN_LO:  r_len[7:0]   <= mem_cmd_dout;
                  HDR_OP:      r_op         <= mem_cmd_dout;
                  HDR_KLEN_HI: r_klen[13:8] <= mem_cmd_dout[5:0];
                  HDR_KLEN_LO: begin
                     r_klen[7:0] <= mem_cmd_dout;
                     if (!w_op_vld || r_len == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= !w_op_vld;
                     end else begin
                        r_state  <= ST_RUN;
                        r_src_ce <= 1'b1;
                        r_src_ad <= '0;
                        r_key_ad <= '0;
                     end
                  end
                  default: ;
               endcase
            end
            ST_RUN: begin
               r_dst_wre <= r_src_ce;
               r_dst_ad  <= r_src_ad;
               if (r_src_ce) begin
                  if (r_src_ad == r_len - 14'd1) begin
                     r_src_ce <= 1'b0;
                  end else begin
                     r_src_ad <= r_src_ad + 14'd1;
                     r_key_ad <= (r_key_ad >= w_kmax) ? '0 : r_key_ad + 14'd1;
                  end
               end else begin
                  // drain write is in flight this cycle; finish next
                  r_state  <= ST_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_src_ad <= '0;
                  r_key_ad <= '0;
                  r_dst_ad <= '0;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef CRYPT_ENGINE_CHECKSUM_EN
   logic [DATA_W-1:0] r_chk;

   // running XOR of every byte written to dst, cleared by an accepted start
   always_ff @(posedge sysclk) begin
      if (arduino_reset) begin
         r_chk <= '0;
      end else if (r_state == ST_IDLE && start) begin
         r_chk <= '0;
      end else if (r_dst_wre) begin
         r_chk <= r_chk ^ w_din;
      end
   end

   assign checksum = r_chk;
`else
   assign checksum = '0;
`endif

   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;
   assign mem_cmd_ad  = r_cmd_ad;
   assign mem_cmd_ce  = r_cmd_ce;
   assign mem_src_ad  = r_src_ad;
   assign mem_src_ce  = r_src_ce;
   assign mem_key_ad  = r_key_ad;
   assign mem_key_ce  = r_src_ce;
   assign mem_dst_ad  = r_dst_ad;
   assign mem_dst_ce  = r_dst_wre;
   assign mem_dst_wre = r_dst_wre;
   assign mem_dst_din = w_din;

endmodule

// File: tb/tb_crypt_engine.sv
// Testbench for crypt_engine: table vectors, multi-cycle corner sequences, random jobs vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_crypt_engine;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy, done, err;
   logic [7:0]  checksum;
   logic [13:0] mem_cmd_ad, mem_src_ad, mem_key_ad, mem_dst_ad;
   logic        mem_cmd_ce, mem_src_ce, mem_key_ce, mem_dst_ce, mem_dst_wre;
   logic [7:0]  mem_cmd_dout, mem_src_dout, mem_key_dout, mem_dst_din;

   logic [7:0]  cmd_m [0:16383];
   logic [7:0]  src_m [0:16383];
   logic [7:0]  key_m [0:16383];
   logic [7:0]  dst_m [0:16383];
   logic [7:0]  exp_m [0:63];
   logic        dst_clr;

   int n_chk = 0;
   int n_err = 0;

   int         g_seen, g_lat, g_wre, g_runs;
   logic       g_err, g_busy_done;
   logic [7:0] g_ck;

   crypt_engine dut (
      .sysclk        (clk),
      .arduino_reset (rst),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .checksum      (checksum),
      .mem_cmd_ad    (mem_cmd_ad),
      .mem_cmd_ce    (mem_cmd_ce),
      .mem_cmd_dout  (mem_cmd_dout),
      .mem_src_ad    (mem_src_ad),
      .mem_src_ce    (mem_src_ce),
      .mem_src_dout  (mem_src_dout),
      .mem_key_ad    (mem_key_ad),
      .mem_key_ce    (mem_key_ce),
      .mem_key_dout  (mem_key_dout),
      .mem_dst_ad    (mem_dst_ad),
      .mem_dst_ce    (mem_dst_ce),
      .mem_dst_wre   (mem_dst_wre),
      .mem_dst_din   (mem_dst_din)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // single-port block memories with one cycle read latency
   always @(posedge clk) begin
      if (mem_cmd_ce) mem_cmd_dout <= cmd_m[mem_cmd_ad];
      if (mem_src_ce) mem_src_dout <= src_m[mem_src_ad];
      if (mem_key_ce) mem_key_dout <= key_m[mem_key_ad];
      if (dst_clr) begin
         for (int i = 0; i < 64; i++) dst_m[i] <= 8'hEE;
      end else if (mem_dst_ce && mem_dst_wre) begin
         dst_m[mem_dst_ad] <= mem_dst_din;
      end
   end

   typedef struct packed {
      logic [13:0]      len;
      logic [7:0]       op;
      logic [13:0]      klen;
      logic             junk;
      logic [0:7][7:0]  src;
      logic [0:3][7:0]  key;
      logic [0:7][7:0]  exp;
      logic [7:0]       ck;
      logic             err;
      logic [7:0]       lat;
   } vec_t;

   vec_t vecs [0:6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_flags"}, 32'({busy, done, err}), 32'd0);
      chk({tag, "_checksum"}, 32'(checksum), 32'd0);
      chk({tag, "_ce_wre"}, 32'({mem_cmd_ce, mem_src_ce, mem_key_ce, mem_dst_ce, mem_dst_wre}), 32'd0);
      chk({tag, "_addr"}, 32'(mem_cmd_ad | mem_src_ad | mem_key_ad | mem_dst_ad), 32'd0);
      chk({tag, "_din"}, 32'(mem_dst_din), 32'd0);
   endtask

   task automatic load_hdr(input logic [13:0] len, input logic [7:0] op, input logic [13:0] klen, input bit junk);
      cmd_m[0] = {junk ? 2'b11 : 2'b00, len[13:8]};
      cmd_m[1] = len[7:0];
      cmd_m[2] = op;
      cmd_m[3] = {junk ? 2'b11 : 2'b00, klen[13:8]};
      cmd_m[4] = klen[7:0];
      @(negedge clk);
      dst_clr = 1'b1;
      @(negedge clk);
      dst_clr = 1'b0;
   endtask

   // expected dst bytes and xor-sum straight from the opcode definitions
   task automatic model(input int len, input logic [7:0] op, input int klen, output logic [7:0] ck);
      int kl;
      logic [7:0] k;
      kl = (klen == 0) ? 1 : klen;
      ck = 8'h00;
      for (int i = 0; i < len; i++) begin
         k = key_m[i % kl];
         case (op)
            8'h00:   exp_m[i] = src_m[i];
            8'h01:   exp_m[i] = src_m[i] ^ k;
            8'h02:   exp_m[i] = 8'((int'(src_m[i]) + int'(k)) % 256);
            8'h03:   exp_m[i] = 8'((int'(src_m[i]) - int'(k) + 256) % 256);
            default: exp_m[i] = ~src_m[i];
         endcase
         ck = ck ^ exp_m[i];
      end
   endtask

   task automatic run_job(input bit repulse);
      int cyc;
      bit prev;
      g_seen = 0; g_lat = 0; g_wre = 0; g_runs = 0; prev = 0;
      g_err = 1'b0; g_ck = 8'h00; g_busy_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      chk("busy_rise", 32'(busy), 32'd1);
      chk("err_clear_on_start", 32'(err), 32'd0);
      while (g_seen == 0 && cyc <= 500) begin
         if (mem_dst_wre) begin
            g_wre++;
            if (!prev) g_runs++;
         end
         prev = mem_dst_wre;
         if (done) begin
            g_seen = 1;
            g_lat = cyc;
            g_err = err;
            g_ck = checksum;
            g_busy_done = busy;
         end else begin
            if (repulse && (cyc == 2 || cyc == 8)) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
         end
      end
      if (g_seen != 0) begin
         chk("busy_low_at_done", 32'(g_busy_done), 32'd0);
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 32'd0);
      end
   endtask

   task automatic verify(input string tag, input int len, input bit exp_err, input int exp_lat, input logic [7:0] exp_ck);
      int nw;
      nw = exp_err ? 0 : len;
      chk({tag, "_done_seen"}, 32'(g_seen), 32'd1);
      chk({tag, "_latency"}, 32'(g_lat), 32'(exp_lat));
      chk({tag, "_err"}, 32'(g_err), 32'(exp_err));
      chk({tag, "_wre_cycles"}, 32'(g_wre), 32'(nw));
      chk({tag, "_wre_bursts"}, 32'(g_runs), (nw > 0) ? 32'd1 : 32'd0);
      for (int i = 0; i < nw; i++) chk({tag, "_dst"}, 32'(dst_m[i]), 32'(exp_m[i]));
      chk({tag, "_dst_beyond"}, 32'(dst_m[nw]), 32'hEE);
`ifdef CRYPT_ENGINE_CHECKSUM_EN
      chk({tag, "_checksum"}, 32'(g_ck), 32'(exp_ck));
`else
      chk({tag, "_checksum"}, 32'(g_ck), 32'(exp_ck & 8'h00));
`endif
   endtask

   task automatic apply_vec(input vec_t v, input bit repulse, input string tag);
      for (int i = 0; i < 64; i++) begin
         src_m[i] = (i < 8) ? v.src[i] : 8'h00;
         key_m[i] = (i < 4) ? v.key[i] : 8'h00;
         exp_m[i] = (i < 8) ? v.exp[i] : 8'h00;
      end
      load_hdr(v.len, v.op, v.klen, v.junk);
      run_job(repulse);
      verify(tag, int'(v.len), v.err, int'(v.lat), v.ck);
   endtask

   initial begin
      logic [7:0] ck;
      int len, klen, wcnt, dcnt;
      logic [7:0] op;

      vecs[0] = '{len: 14'd4, op: 8'h01, klen: 14'd2, junk: 1'b0,
                  src: {8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00},
                  key: {8'hF0, 8'h0F, 8'h00, 8'h00},
                  exp: {8'hE1, 8'h2D, 8'hC3, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00},
                  ck: 8'h44, err: 1'b0, lat: 8'd12};
      vecs[1] = '{len: 14'd2, op: 8'h02, klen: 14'd1, junk: 1'b0,
                  src: {8'hFF, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  key: {8'h02, 8'h55, 8'h00, 8'h00},
                  exp: {8'h01, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  ck: 8'h83, err: 1'b0, lat: 8'd10};
      vecs[2] = '{len: 14'd0, op: 8'h00, klen: 14'd1, junk: 1'b0,
                  src: {8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  key: {8'h00, 8'h00, 8'h00, 8'h00},
                  exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  ck: 8'h00, err: 1'b0, lat: 8'd7};
      vecs[3] = '{len: 14'd3, op: 8'h07, klen: 14'd1, junk: 1'b0,
                  src: {8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  key: {8'h10, 8'h00, 8'h00, 8'h00},
                  exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  ck: 8'h00, err: 1'b1, lat: 8'd7};
      vecs[4] = '{len: 14'd3, op: 8'h03, klen: 14'd0, junk: 1'b0,
                  src: {8'h10, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  key: {8'h20, 8'h77, 8'h00, 8'h00},
                  exp: {8'hF0, 8'hE0, 8'hE5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  ck: 8'hF5, err: 1'b0, lat: 8'd11};
      vecs[5] = '{len: 14'd2, op: 8'h04, klen: 14'd1, junk: 1'b0,
                  src: {8'h0F, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  key: {8'h33, 8'h00, 8'h00, 8'h00},
                  exp: {8'hF0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  ck: 8'hAA, err: 1'b0, lat: 8'd10};
      vecs[6] = '{len: 14'd5, op: 8'h01, klen: 14'd3, junk: 1'b1,
                  src: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  key: {8'h01, 8'h02, 8'h03, 8'h04},
                  exp: {8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00},
                  ck: 8'h03, err: 1'b0, lat: 8'd13};

      rst = 1'b1;
      start = 1'b0;
      dst_clr = 1'b0;
      for (int i = 0; i < 5; i++) cmd_m[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("idle");

      // table vectors, including err set by bad opcode then cleared by the next job
      for (int v = 0; v < 7; v++) apply_vec(vecs[v], 1'b0, $sformatf("vec%0d", v));

      // start pulses while busy must not disturb the job
      apply_vec(vecs[6], 1'b1, "repulse");

      // reset in the middle of RUN after three writes
      for (int i = 0; i < 64; i++) begin
         src_m[i] = 8'($urandom);
         key_m[i] = 8'($urandom);
      end
      model(10, 8'h01, 3, ck);
      load_hdr(14'd10, 8'h01, 14'd3, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wcnt = 0;
      for (int c = 0; c < 100 && wcnt < 3; c++) begin
         if (mem_dst_wre) wcnt++;
         if (wcnt < 3) @(negedge clk);
      end
      chk("midrun_writes_seen", 32'(wcnt), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrun_reset");
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      chk("midrun_no_done", 32'(dcnt), 32'd0);
      for (int i = 0; i < 3; i++) chk("midrun_dst_written", 32'(dst_m[i]), 32'(exp_m[i]));
      for (int i = 3; i < 10; i++) chk("midrun_dst_untouched", 32'(dst_m[i]), 32'hEE);

      // random jobs against the reference model
      for (int t = 0; t < 15; t++) begin
         len  = $urandom_range(0, 40);
         klen = $urandom_range(0, 6);
         op   = 8'($urandom_range(0, 6));
         for (int i = 0; i < 64; i++) begin
            src_m[i] = 8'($urandom);
            key_m[i] = 8'($urandom);
         end
         model(len, op, klen, ck);
         load_hdr(14'(len), op, 14'(klen), 1'($urandom_range(0, 1)));
         run_job(1'b0);
         if (op > 8'h04) verify("rand", len, 1'b1, 7, 8'h00);
         else verify("rand", len, 1'b0, (len == 0) ? 7 : len + 8, ck);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
